ser_par: RTL and testbench

Serial-to-parallel converter: the receive end of the team's MSB-first parallel-to-serial link. A one-cycle `strobe` marks the start of a frame. The block then shifts in `WIDTH` serial bits, one per clock, and presents the assembled word on `d_out` with a one-cycle `valid` pulse. It sits directly downstream of the serializer's `d_out`, sharing its clock and its `strobe`.

---
 rtl/ser_par.sv | 136 +++++++++++++
 tb/tb_ser_par.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ser_par.sv
// Serial-to-parallel receiver for the MSB-first link; one word per strobe.
// Optional even-parity bit after the data word: define SER_PAR_PARITY_EN.
module ser_par #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe,
    input  logic             d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             valid,
    output logic             busy,
    output logic             abort,
    output logic             par_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] d_out_q, d_out_d;
    logic             valid_q, valid_d;
    logic             abort_q, abort_d;
    logic             last;

`ifdef SER_PAR_PARITY_EN
    logic             par_err_q, par_err_d;
`endif

    assign last = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        d_out_d = d_out_q;
        valid_d = 1'b0;
        abort_d = 1'b0;
`ifdef SER_PAR_PARITY_EN
        par_err_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (strobe) begin
                    state_d = RECV;
                    cnt_d   = '0;
                end
            end
            RECV: begin
                sh_d  = {sh_q[WIDTH-2:0], d_in};
                cnt_d = cnt_q + 1'b1;
`ifdef SER_PAR_PARITY_EN
                // Word is not complete until the parity bit arrives.
                if (strobe) begin
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else if (last) begin
                    state_d = PAR;
                end
`else
                if (last) begin
                    d_out_d = sh_d;
                    valid_d = 1'b1;
                    if (strobe) begin
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (strobe) begin
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end
`endif
            end
`ifdef SER_PAR_PARITY_EN
            PAR: begin
                if (strobe) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else begin
                    d_out_d   = sh_q;
                    valid_d   = 1'b1;
                    par_err_d = ^{sh_q, d_in};
                    state_d   = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            d_out_q <= '0;
            valid_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            d_out_q <= d_out_d;
            valid_q <= valid_d;
            abort_q <= abort_d;
        end
    end

`ifdef SER_PAR_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end
    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    assign d_out = d_out_q;
    assign valid = valid_q;
    assign abort = abort_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_ser_par.sv
// Scoreboard bench for ser_par: stimulus pushes expected words,
// a negedge monitor pops and compares on every valid pulse.
module tb_ser_par;

    localparam int W = 8;
`ifdef SER_PAR_PARITY_EN
    localparam int LAT = W + 1;
    localparam bit PEN = 1'b1;
`else
    localparam int LAT = W;
    localparam bit PEN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         strobe = 1'b0;
    logic         d_in = 1'b0;
    logic [W-1:0] d_out;
    logic         valid;
    logic         busy;
    logic         abort;
    logic         par_err;

    ser_par #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .strobe (strobe),
        .d_in   (d_in),
        .d_out  (d_out),
        .valid  (valid),
        .busy   (busy),
        .abort  (abort),
        .par_err(par_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] w;
        logic         pe;
        int           at;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int aborts_seen = 0;
    int aborts_exp = 0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (valid) begin
                if (q.size() == 0) begin
                    chk("valid_unexpected", valid, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("d_out", d_out, e.w);
                    chk("valid_cycle", cyc, e.at);
                    chk("par_err", par_err, e.pe);
                    chk("valid_abort_excl", abort, 0);
                end
            end
            if (abort) aborts_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] w, input logic pb);
        exp_t e;
        e.w  = w;
        e.pe = PEN ? ^{w, pb} : 1'b0;
        e.at = cyc + LAT;
        q.push_back(e);
    endtask

    task automatic start();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
    endtask

    task automatic shift(input logic [W-1:0] w, input logic pb,
                         input bit sl);
        for (int i = W - 1; i >= 0; i--) begin
            d_in   = w[i];
            strobe = (i == 0) && sl && !PEN;
            tick();
        end
        strobe = 1'b0;
        if (PEN) begin
            d_in = pb;
            tick();
        end
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_d_out", d_out, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_abort", abort, 0);
        chk("rst_par_err", par_err, 0);
        rst = 1'b1;
        tick();

        // single word
        start();
        push(8'hA5, 1'b0);
        @(negedge clk);
        chk("busy_after_strobe", busy, 1);
        shift(8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        chk("busy_after_word", busy, 0);
        tick();
        @(negedge clk);
        chk("valid_one_cycle", valid, 0);
        chk("d_out_held", d_out, 8'hA5);

        // back-to-back
        start();
        push(8'h3C, 1'b0);
        shift(8'h3C, 1'b0, 1'b1);
        if (PEN) start();
        push(8'hC3, 1'b0);
        shift(8'hC3, 1'b0, 1'b0);
        repeat (2) tick();

        // abort at E4
        start();
        d_in = 1'b1; tick();
        d_in = 1'b0; tick();
        d_in = 1'b1; tick();
        strobe = 1'b1;
        d_in = 1'b0;
        tick();
        strobe = 1'b0;
        aborts_exp++;
        @(negedge clk);
        chk("abort_pulse", abort, 1);
        chk("d_out_hold_abort", d_out, 8'hC3);
        push(8'h5A, 1'b0);
        shift(8'h5A, 1'b0, 1'b0);
        repeat (2) tick();

        // reset mid-frame
        start();
        d_in = 1'b1; tick();
        d_in = 1'b1; tick();
        d_in = 1'b0; tick();
        #1 rst = 1'b0;
        #1;
        chk("midrst_d_out", d_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", valid, 0);
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d_in = ~d_in;
            tick();
            @(negedge clk);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_d_out", d_out, 0);
        end

        // idle noise
        start();
        push(8'h81, 1'b0);
        shift(8'h81, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            d_in = ~d_in;
            tick();
            @(negedge clk);
            chk("noise_busy", busy, 0);
            chk("noise_d_out", d_out, 8'h81);
        end

`ifdef SER_PAR_PARITY_EN
        start();
        push(8'hA5, 1'b0);
        shift(8'hA5, 1'b0, 1'b0);
        tick();
        start();
        push(8'hA5, 1'b1);
        shift(8'hA5, 1'b1, 1'b0);
        tick();
`endif

        repeat (3) tick();
        chk("pending_words", q.size(), 0);
        chk("abort_count", aborts_seen, aborts_exp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
